// File: rtl/score_digit_display_if.sv
// Request/response bundle between a score source and the seven-segment driver.
interface score_digit_display_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
);
  logic [WIDTH-1:0]    value;
  logic                load;
  logic                mode;
  logic                blank_lz;
  logic                busy;
  logic                done;
  logic                overflow;
  logic [7*DIGITS-1:0] hex_out;

  modport master (output value, load, mode, blank_lz,
                  input  busy, done, overflow, hex_out);
  modport slave  (input  value, load, mode, blank_lz,
                  output busy, done, overflow, hex_out);
endinterface

// File: rtl/score_digit_display.sv
// Multi-digit active-low seven-segment driver: hex or double-dabble decimal,
// leading-zero blanking, overflow dashes, frame held until the next update.
module score_digit_display #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  resetn,
  score_digit_display_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic                blz_q, blz_d;
  logic                sticky_q, sticky_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  // Zero-extending first keeps the hex slice/overflow legal for any WIDTH vs DIGITS.
  logic [BW+WIDTH-1:0] ext;
  logic [BW-1:0]       digits;
  logic                frame_ovf;
  logic [DIGITS-1:0]   lit;
  logic [7*DIGITS-1:0] frame;
  logic [BW-1:0]       adj;

  assign ext       = {{BW{1'b0}}, bin_q};
  assign digits    = mode_q ? bcd_q : ext[BW-1:0];
  assign frame_ovf = mode_q ? sticky_q : (|(ext >> BW));

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    // lit[k]: this digit or some more significant digit is nonzero
    assign lit[k] = |(digits >> (4 * k));
    assign frame[7*k +: 7] = frame_ovf                            ? 7'h3F :
                             ((k != 0) && blz_q && !lit[k])       ? 7'h7F :
                             seg7(digits[4*k +: 4]);
  end

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++)
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    blz_d    = blz_q;
    sticky_d = sticky_q;
    hex_d    = hex_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.load) begin
        bin_d    = bus.value;
        mode_d   = bus.mode;
        blz_d    = bus.blank_lz;
        bcd_d    = '0;
        sticky_d = 1'b0;
        cnt_d    = '0;
        state_d  = bus.mode ? CONV : UPDATE;
      end
      CONV: begin
        sticky_d = sticky_q | adj[BW-1];
        bcd_d    = {adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d    = bin_q << 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        hex_d   = frame;
        ovf_d   = frame_ovf;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      blz_q    <= 1'b0;
      sticky_q <= 1'b0;
      hex_q    <= '1;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      blz_q    <= blz_d;
      sticky_q <= sticky_d;
      hex_q    <= hex_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.hex_out  = hex_q;
endmodule

// File: tb/tb_score_digit_display.sv
// Directed bench for score_digit_display (DIGITS=4, WIDTH=14).
module tb_score_digit_display;
  localparam logic [27:0] DARK = {4{7'h7F}};
  localparam logic [27:0] DASH = {4{7'h3F}};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  score_digit_display_if #(.DIGITS(4), .WIDTH(14)) bus ();
  score_digit_display #(.DIGITS(4), .WIDTH(14)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Load is driven for one cycle (cycle n); returns during cycle n+1.
  task automatic start(input logic [13:0] v, input logic m, input logic b);
    @(negedge clk);
    bus.value = v; bus.mode = m; bus.blank_lz = b; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Called in cycle n+1; returns offset of the done cycle, or -1 on timeout.
  task automatic wait_done(input int maxoff, output int off);
    off = 1;
    while (bus.done !== 1'b1 && off < maxoff) begin
      @(negedge clk);
      off++;
    end
    if (bus.done !== 1'b1) off = -1;
  endtask

  task automatic test_reset();
    bus.value = '0; bus.mode = 1'b0; bus.blank_lz = 1'b0; bus.load = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.hex_out !== DARK) begin n_err++; $display("FAIL reset_hex got %h want %h", bus.hex_out, DARK); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_dec_1234();
    logic [27:0] exp = {7'h79, 7'h24, 7'h30, 7'h19};
    start(14'd1234, 1'b1, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      n_vec++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.hex_out !== DARK) begin
        n_err++; $display("FAIL dec1234_busy cyc n+%0d busy=%b done=%b hex=%h want busy=1 done=0 hex=%h", c, bus.busy, bus.done, bus.hex_out, DARK);
      end
      @(negedge clk);
    end
    n_vec++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL dec1234_done done=%b busy=%b want 1/0", bus.done, bus.busy); end
    n_vec++; if (bus.hex_out !== exp) begin n_err++; $display("FAIL dec1234_hex got %h want %h", bus.hex_out, exp); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL dec1234_ovf got %b want 0", bus.overflow); end
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL dec1234_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_overflow();
    int off;
    logic [27:0] exp9 = {4{7'h10}};
    start(14'd10000, 1'b1, 1'b1);
    wait_done(40, off);
    n_vec++; if (off !== 16) begin n_err++; $display("FAIL ovf_latency got %0d want 16", off); end
    n_vec++; if (bus.hex_out !== DASH) begin n_err++; $display("FAIL ovf_hex got %h want %h", bus.hex_out, DASH); end
    n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
    start(14'd9999, 1'b1, 1'b0);
    wait_done(40, off);
    n_vec++; if (off !== 16) begin n_err++; $display("FAIL dec9999_latency got %0d want 16", off); end
    n_vec++; if (bus.hex_out !== exp9) begin n_err++; $display("FAIL dec9999_hex got %h want %h", bus.hex_out, exp9); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL dec9999_ovf got %b want 0", bus.overflow); end
  endtask

  task automatic test_blank();
    int off;
    logic [13:0] vals [3] = '{14'd7, 14'd0, 14'd305};
    logic [27:0] exps [3] = '{{7'h7F, 7'h7F, 7'h7F, 7'h78},
                              {7'h7F, 7'h7F, 7'h7F, 7'h40},
                              {7'h7F, 7'h30, 7'h40, 7'h12}};
    for (int i = 0; i < 3; i++) begin
      start(vals[i], 1'b1, 1'b1);
      wait_done(40, off);
      n_vec++; if (off !== 16 || bus.hex_out !== exps[i]) begin
        n_err++; $display("FAIL blank_dec_%0d off=%0d hex=%h want off=16 hex=%h", vals[i], off, bus.hex_out, exps[i]);
      end
    end
  endtask

  task automatic test_back_to_back_hex();
    logic [27:0] e1 = {7'h24, 7'h08, 7'h12, 7'h0E};
    logic [27:0] e2 = {7'h79, 7'h24, 7'h30, 7'h19};
    logic [27:0] e3 = {7'h7F, 7'h7F, 7'h08, 7'h12};
    start(14'h2A5F, 1'b0, 1'b0);
    n_vec++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_err++; $display("FAIL hex_n1 busy=%b done=%b want 1/0", bus.busy, bus.done); end
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.hex_out !== e1) begin
      n_err++; $display("FAIL hex_2a5f done=%b busy=%b hex=%h want 1/0 %h", bus.done, bus.busy, bus.hex_out, e1);
    end
    bus.value = 14'h1234; bus.mode = 1'b0; bus.blank_lz = 1'b0; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    n_vec++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.hex_out !== e1) begin
      n_err++; $display("FAIL hex_hold busy=%b done=%b hex=%h want 1/0 %h", bus.busy, bus.done, bus.hex_out, e1);
    end
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b1 || bus.hex_out !== e2) begin
      n_err++; $display("FAIL hex_b2b done=%b hex=%h want 1 %h", bus.done, bus.hex_out, e2);
    end
    start(14'h00A5, 1'b0, 1'b1);
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b1 || bus.hex_out !== e3 || bus.overflow !== 1'b0) begin
      n_err++; $display("FAIL hex_blank done=%b hex=%h ovf=%b want 1 %h 0", bus.done, bus.hex_out, bus.overflow, e3);
    end
  endtask

  task automatic test_ignored_load();
    int dones = 0;
    int first = -1;
    logic [27:0] seen = '0;
    logic [27:0] exp = {7'h40, 7'h40, 7'h19, 7'h24};
    start(14'd42, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    bus.value = 14'h1111; bus.mode = 1'b0; bus.blank_lz = 1'b0; bus.load = 1'b1;
    for (int c = 6; c <= 35; c++) begin
      @(negedge clk);
      bus.load = 1'b0;
      if (bus.done === 1'b1) begin
        dones++;
        if (first < 0) begin first = c; seen = bus.hex_out; end
      end
    end
    n_vec++; if (dones !== 1 || first !== 16) begin n_err++; $display("FAIL ignore_dones count=%0d first=n+%0d want 1 at n+16", dones, first); end
    n_vec++; if (seen !== exp) begin n_err++; $display("FAIL ignore_hex got %h want %h", seen, exp); end
  endtask

  task automatic test_reset_mid_conv();
    int off;
    int dones = 0;
    logic [27:0] exp = {7'h12, 7'h02, 7'h78, 7'h00};
    start(14'd5678, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_vec++; if (bus.hex_out !== DARK || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
      n_err++; $display("FAIL midreset hex=%h busy=%b done=%b ovf=%b want %h 0 0 0", bus.hex_out, bus.busy, bus.done, bus.overflow, DARK);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    n_vec++; if (dones !== 0 || bus.hex_out !== DARK) begin n_err++; $display("FAIL midreset_quiet activity=%0d hex=%h want 0 %h", dones, bus.hex_out, DARK); end
    start(14'd5678, 1'b1, 1'b0);
    wait_done(40, off);
    n_vec++; if (off !== 16 || bus.hex_out !== exp) begin
      n_err++; $display("FAIL midreset_reload off=%0d hex=%h want 16 %h", off, bus.hex_out, exp);
    end
  endtask

  initial begin
    test_reset();
    test_dec_1234();
    test_overflow();
    test_blank();
    test_back_to_back_hex();
    test_ignored_load();
    test_reset_mid_conv();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
